prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter WIDTH, default 16: number of history bits, equal to the generator LFSR width.
REQ-002 Parameter POLY, default 16'h6801: feedback polynomial, bit i = coefficient of x^i; x^WIDTH is implicit.
REQ-003 Parameter LOCK_CNT, default 32: consecutive matches needed to lock, and to clear the loss counter.
REQ-004 Parameter LOSS_THRESH, default 8: mismatches that drop lock.
REQ-005 Parameter ERRCNT_W, default 16: error counter width.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_b  input  1  reset, asynchronous, active-low.
REQ-008 clear  input  1  synchronous clear of err_cnt.
REQ-009 din_valid  input  1  din qualifier; state advances only when high.
REQ-010 din  input  1  received serial PRBS bit.
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 err  output  1  registered one-cycle pulse per mismatch while LOCKED.
REQ-013 err_cnt  output  ERRCNT_W  saturating count of LOCKED mismatches.

Function
REQ-014 Expected stream: MSB of a Galois LFSR shifting toward MSB with POLY and din=0, i.e. s[t+WIDTH] = XOR of s[t+i] for every i with POLY[i]=1.
REQ-015 Register hist[WIDTH-1:0] shall, on each valid bit, shift toward MSB with din entering bit 0, so hist[j] holds the bit received j+1 valid bits earlier.
REQ-016 expected = XOR of hist[WIDTH-1-i] over all i with POLY[i]=1; mismatch = din_valid & fill_done & (din != expected).
REQ-017 fill counter shall count valid bits from reset; fill_done asserts once WIDTH bits are in hist and no comparison is made before that.
REQ-018 FSM states SEARCH and LOCKED; reset state SEARCH.
REQ-019 SEARCH: match_cnt increments on each compared match and clears on mismatch; reaching LOCK_CNT moves to LOCKED on that edge, with loss_cnt=0.
REQ-020 LOCKED: a mismatch increments loss_cnt, clears match_cnt, pulses err and increments err_cnt; a match increments match_cnt; at LOCK_CNT, loss_cnt and match_cnt clear.
REQ-021 LOCKED→SEARCH on the mismatch bringing loss_cnt to LOSS_THRESH; that mismatch is still counted; match_cnt=0; hist is not refilled.
REQ-022 locked and err shall be registered, changing in the cycle after the deciding valid bit; with din_valid low, err=0 and all state holds.
REQ-023 err_cnt shall saturate at 2^ERRCNT_W-1; clear coincident with a mismatch yields 0 (clear wins).
REQ-024 Counters shall be sized ceil(log2(max+1)) and shall not wrap.

Reset
REQ-025 rst_b low shall asynchronously set hist=0, fill counter=0, match_cnt=0, loss_cnt=0, state=SEARCH, locked=0, err=0, err_cnt=0, including mid-lock.
REQ-026 After reset release, behaviour shall match REQ-017 from zero filled bits.

Configuration
REQ-027 Macro PRBS_CHK_ERRCNT_EN defined: err_cnt register and clear logic present per REQ-013/REQ-023.
REQ-028 Macro PRBS_CHK_ERRCNT_EN undefined: no counter register; err_cnt tied to 0; clear ignored; locked and err unchanged.

Verification
All scenarios use defaults; the generator is the REQ-014 LFSR with seed 16'hACE1.
REQ-029 Clean stream, din_valid=1, 200 bits: locked rises in the cycle after valid bit 48; err never asserts; err_cnt=0.
REQ-030 din_valid toggled pseudo-randomly at 50%: locked rises after the same 48th valid bit; no err.
REQ-031 Single flipped bit after lock: exactly 5 err pulses (own bit + 4 taps 0,11,13,14); err_cnt=5; locked stays 1.
REQ-032 Stream switched to constant 1 after lock: err pulses on each of 8 valid bits; locked falls after the 8th; err_cnt=8 then frozen.
REQ-033 ERRCNT_W=3 with two single flips separated by at least 40 clean bits: err_cnt saturates at 7; clear then gives 0.
REQ-034 rst_b pulsed low mid-lock: locked, err and err_cnt are 0 immediately; relock after 48 further valid bits.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: predicts each bit from the last WIDTH received bits and locks after LOCK_CNT matches.
// Define PRBS_CHK_ERRCNT_EN to build the saturating err_cnt register; otherwise err_cnt reads 0 and clear is ignored.
module prbs_checker #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'h6801,
  parameter int              LOCK_CNT    = 32,
  parameter int              LOSS_THRESH = 8,
  parameter int              ERRCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                clear,
  input  logic                din_valid,
  input  logic                din,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [WIDTH-1:0]   hist;
  logic [FILL_W-1:0]  fill;
  logic [MATCH_W-1:0] match_cnt;
  logic [LOSS_W-1:0]  loss_cnt;
  logic [0:0]         state;
  logic               fill_done;
  logic               expected;
  logic               mismatch;
  logic               compare;
  logic               lock_err;

  // Taps are read MSB-first so that POLY bit i selects the bit received WIDTH-i bits ago.
  always_comb begin
    expected = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (POLY[i]) expected = expected ^ hist[WIDTH-1-i];
    end
  end

  assign fill_done = (fill == FILL_W'(WIDTH));
  assign compare   = din_valid & fill_done;
  assign mismatch  = compare & (din != expected);
  assign lock_err  = mismatch & (state == LOCKED);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hist <= '0;
      fill <= '0;
    end else if (din_valid) begin
      hist <= {hist[WIDTH-2:0], din};
      if (!fill_done) fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= SEARCH;
      match_cnt <= '0;
      loss_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      err <= lock_err;
      if (compare) begin
        if (state == SEARCH) begin
          if (mismatch) begin
            match_cnt <= '0;
          end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
            state     <= LOCKED;
            match_cnt <= '0;
            loss_cnt  <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          if (mismatch) begin
            match_cnt <= '0;
            if (loss_cnt == LOSS_W'(LOSS_THRESH - 1)) begin
              state    <= SEARCH;
              loss_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + 1'b1;
            end
          end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
            // A full clean run forgives earlier losses.
            match_cnt <= '0;
            loss_cnt  <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef PRBS_CHK_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (lock_err && (cnt_q != {ERRCNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a reference model built on a queue of received bits and the stream recurrence.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_b, clear, din_valid, din;
  logic        locked, err, locked3, err3;
  logic [15:0] err_cnt;
  logic [2:0]  err_cnt3;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .din_valid(din_valid), .din(din),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  prbs_checker #(.ERRCNT_W(3)) u_dut3 (
    .clk(clk), .rst_b(rst_b), .clear(clear), .din_valid(din_valid), .din(din),
    .locked(locked3), .err(err3), .err_cnt(err_cnt3)
  );

`ifdef PRBS_CHK_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Generator: Galois LFSR shifting toward MSB, output taken from the MSB.
  logic [15:0] gen;
  task automatic next_gen(output logic b);
    b   = gen[15];
    gen = {gen[14:0], 1'b0} ^ (b ? 16'h6801 : 16'h0000);
  endtask

  // Reference model state.
  bit hq[$];
  int m_match, m_loss, m_cnt, m_cnt3;
  bit m_locked, m_err;
  int vcount, lock_at, err_seen;

  task automatic model_reset();
    hq.delete();
    m_match = 0; m_loss = 0; m_cnt = 0; m_cnt3 = 0;
    m_locked = 0; m_err = 0;
    vcount = 0; lock_at = -1;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit pred, mis;
    m_err = 0;
    if (v) begin
      if (hq.size() == 16) begin
        // s[t] = s[t-16] ^ s[t-5] ^ s[t-3] ^ s[t-2]; hq[0] is the oldest of the last 16
        pred = hq[0] ^ hq[11] ^ hq[13] ^ hq[14];
        mis  = (d != pred);
        if (!m_locked) begin
          if (mis) m_match = 0;
          else begin
            m_match++;
            if (m_match == 32) begin m_locked = 1; m_match = 0; m_loss = 0; end
          end
        end else if (mis) begin
          m_err = 1; m_match = 0; m_loss++;
          if (m_loss == 8) begin m_locked = 0; m_loss = 0; end
        end else begin
          m_match++;
          if (m_match == 32) begin m_match = 0; m_loss = 0; end
        end
      end
      hq.push_back(d);
      if (hq.size() > 16) void'(hq.pop_front());
    end
    if (c) begin
      m_cnt = 0; m_cnt3 = 0;
    end else if (m_err) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
  endtask

  task automatic cycle(input bit v, input bit d, input bit c);
    din_valid = v; din = d; clear = c;
    @(posedge clk); #1;
    model_step(v, d, c);
    check("locked", locked, m_locked);
    check("err", err, m_err);
    check("err_cnt", err_cnt, CNT_EN ? m_cnt : 0);
    check("err_cnt_w3", err_cnt3, CNT_EN ? m_cnt3 : 0);
    if (v) vcount++;
    if (err) err_seen++;
    if (locked && lock_at < 0) lock_at = vcount;
  endtask

  // Sends n generator bits; optionally the first is inverted and/or paired with clear.
  task automatic send_gen(input int n, input bit flip_first, input bit clr_first, input bit rand_valid);
    logic b;
    int sent = 0, guard = 0;
    while (sent < n && guard < 20 * n) begin
      guard++;
      if (rand_valid && $urandom_range(0, 1) == 0) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        next_gen(b);
        cycle(1'b1, b ^ (flip_first && sent == 0), clr_first && sent == 0);
        sent++;
      end
    end
    check("send_budget", sent, n);
  endtask

  typedef struct packed {
    logic vld;
    logic d;
    logic clr;
    logic exp_locked;
    logic exp_err;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_b = 1'b0; clear = 1'b0; din_valid = 1'b0; din = 1'b0;
    model_reset();
    err_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", locked, 0);
    check("reset_err", err, 0);
    check("reset_err_cnt", err_cnt, 0);
    @(negedge clk) rst_b = 1'b1;

    // Idle cycles: nothing may move while din_valid is low.
    for (int i = 0; i < 5; i++) begin
      din_valid = tbl[i].vld; din = tbl[i].d; clear = tbl[i].clr;
      @(posedge clk); #1;
      model_step(tbl[i].vld, tbl[i].d, tbl[i].clr);
      check("tbl_locked", locked, tbl[i].exp_locked);
      check("tbl_err", err, tbl[i].exp_err);
      check("tbl_err_cnt", err_cnt, 0);
    end

    // Clean continuous stream.
    gen = 16'hACE1;
    err_seen = 0;
    send_gen(200, 1'b0, 1'b0, 1'b0);
    check("clean_lock_at", lock_at, 48);
    check("clean_no_err", err_seen, 0);
    check("clean_err_cnt", err_cnt, 0);

    // One flipped bit: itself plus four tap echoes.
    err_seen = 0;
    send_gen(60, 1'b1, 1'b0, 1'b0);
    check("flip1_pulses", err_seen, 5);
    check("flip1_locked", locked, 1);
    check("flip1_err_cnt", err_cnt, CNT_EN ? 5 : 0);

    // Second flip saturates the 3-bit counter.
    err_seen = 0;
    send_gen(60, 1'b1, 1'b0, 1'b0);
    check("flip2_pulses", err_seen, 5);
    check("flip2_err_cnt", err_cnt, CNT_EN ? 10 : 0);
    check("flip2_sat_w3", err_cnt3, CNT_EN ? 7 : 0);
    cycle(1'b0, 1'b0, 1'b1);
    check("clear_err_cnt", err_cnt, 0);
    check("clear_err_cnt_w3", err_cnt3, 0);

    // Clear coincident with a mismatch wins; later echoes still count.
    send_gen(1, 1'b1, 1'b1, 1'b0);
    check("clr_vs_err_pulse", err, 1);
    check("clr_vs_err_cnt", err_cnt, 0);
    send_gen(59, 1'b0, 1'b0, 1'b0);
    check("clr_vs_err_after", err_cnt, CNT_EN ? 4 : 0);

    // Asynchronous reset mid-lock, away from any clock edge.
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_err", err, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_err_cnt_w3", err_cnt3, 0);
    model_reset();
    @(negedge clk) rst_b = 1'b1;

    // Relock with din_valid randomly gapped.
    gen = 16'hACE1;
    err_seen = 0;
    send_gen(120, 1'b0, 1'b0, 1'b1);
    check("gapped_lock_at", lock_at, 48);
    check("gapped_no_err", err_seen, 0);

    // Constant-1 stream drops lock after LOSS_THRESH mismatches.
    err_seen = 0;
    for (int i = 0; i < 200 && locked; i++) cycle(1'b1, 1'b1, 1'b0);
    check("ones_unlocked", locked, 0);
    check("ones_pulses", err_seen, 8);
    check("ones_err_cnt", err_cnt, CNT_EN ? 8 : 0);
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    check("ones_frozen_cnt", err_cnt, CNT_EN ? 8 : 0);
    check("ones_frozen_pulses", err_seen, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
